// File: rtl/io_port_unit.sv
`default_nettype none
// ============================================================================
// io_port_unit : execute-stage responder for in/out instructions; serialises
// out words into tx bytes and assembles rx bytes into in results.
// Revision 1.0
// ============================================================================
module io_port_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             out_issued,
  input  logic             in_issued,
  input  logic             size_word,
  input  logic [XLEN-1:0]  out_data,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic             stall,
  output logic             in_done,
  output logic [XLEN-1:0]  in_data,
  output logic [CNT_W-1:0] tx_bytes,
  output logic [CNT_W-1:0] rx_bytes
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TX   = 2'd1,
    RX   = 2'd2
  } state_e;

  state_e           state_q;
  logic [1:0]       cnt_q;
  logic [XLEN-1:0]  sh_q;
  logic [XLEN-1:0]  rxbuf_q;
  logic             size_word_q;
  logic [CNT_W-1:0] tx_bytes_q;
  logic [CNT_W-1:0] rx_bytes_q;

  logic w_last;
  logic w_tx_fire;
  logic w_rx_fire;

  assign w_last    = (cnt_q == (size_word_q ? 2'd3 : 2'd0));
  assign w_tx_fire = (state_q == TX) && tx_ready;
  assign w_rx_fire = (state_q == RX) && rx_valid;

  assign tx_valid = (state_q == TX);
  assign tx_data  = sh_q[7:0];
  assign rx_ready = (state_q == RX);
  assign tx_bytes = tx_bytes_q;
  assign rx_bytes = rx_bytes_q;

  // Final rx byte goes straight to writeback so the result is seen at the retiring edge.
  assign in_done = w_rx_fire && w_last;

  always_comb begin
    in_data = '0;
    if (in_done) begin
      if (size_word_q) begin
        in_data = {rx_data, rxbuf_q[23:0]};
      end else begin
        in_data = {{(XLEN-8){1'b0}}, rx_data};
      end
    end
  end

  always_comb begin
    stall = 1'b0;
    case (state_q)
      IDLE:    stall = out_issued || in_issued;
      TX:      stall = !(w_tx_fire && w_last);
      RX:      stall = !(w_rx_fire && w_last);
      default: stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      sh_q        <= '0;
      rxbuf_q     <= '0;
      size_word_q <= 1'b0;
      tx_bytes_q  <= '0;
      rx_bytes_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // out has priority if decode ever flags both
          if (out_issued) begin
            sh_q        <= out_data;
            size_word_q <= size_word;
            cnt_q       <= 2'd0;
            state_q     <= TX;
          end else if (in_issued) begin
            rxbuf_q     <= '0;
            size_word_q <= size_word;
            cnt_q       <= 2'd0;
            state_q     <= RX;
          end
        end
        TX: begin
          if (w_tx_fire) begin
            tx_bytes_q <= tx_bytes_q + CNT_W'(1);
            if (w_last) begin
              state_q <= IDLE;
            end else begin
              sh_q  <= sh_q >> 8;
              cnt_q <= cnt_q + 2'd1;
            end
          end
        end
        RX: begin
          if (w_rx_fire) begin
            rx_bytes_q <= rx_bytes_q + CNT_W'(1);
            if (w_last) begin
              state_q <= IDLE;
            end else begin
              rxbuf_q[8*cnt_q +: 8] <= rx_data;
              cnt_q                 <= cnt_q + 2'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_io_port_unit.sv
`default_nettype none
// ============================================================================
// tb_io_port_unit : directed self-checking bench for io_port_unit.
// Revision 1.0
// ============================================================================
module tb_io_port_unit;

  logic        clk;
  logic        rstn;
  logic        out_issued;
  logic        in_issued;
  logic        size_word;
  logic [31:0] out_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        stall;
  logic        in_done;
  logic [31:0] in_data;
  logic [31:0] tx_bytes;
  logic [31:0] rx_bytes;

  int checks;
  int errors;

  io_port_unit #(.XLEN(32), .CNT_W(32)) u_dut (
    .clk        (clk),
    .rstn       (rstn),
    .out_issued (out_issued),
    .in_issued  (in_issued),
    .size_word  (size_word),
    .out_data   (out_data),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .stall      (stall),
    .in_done    (in_done),
    .in_data    (in_data),
    .tx_bytes   (tx_bytes),
    .rx_bytes   (rx_bytes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled 1 time unit later.
  task automatic cyc();
    @(negedge clk);
  endtask

  logic [7:0] tx_exp [4];
  logic [7:0] rx_src [4];
  int         k;
  int         pulses;
  logic       exp_done;

  initial begin
    checks = 0; errors = 0;
    rstn = 1'b0; out_issued = 1'b0; in_issued = 1'b0; size_word = 1'b0;
    out_data = '0; tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;
    cyc(); cyc();
    rstn = 1'b1;
    #1;
    chk("rst_stall",    stall,    0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_rx_ready", rx_ready, 0);
    chk("rst_in_done",  in_done,  0);
    chk("rst_in_data",  in_data,  0);
    chk("rst_tx_bytes", tx_bytes, 0);
    chk("rst_rx_bytes", rx_bytes, 0);

    // 1: out byte
    cyc(); out_issued = 1'b1; size_word = 1'b0; out_data = 32'hDEADBEEF; tx_ready = 1'b1; #1;
    chk("t1_acc_stall", stall, 1);
    chk("t1_acc_txv",   tx_valid, 0);
    cyc(); #1;
    chk("t1_txv",   tx_valid, 1);
    chk("t1_data",  tx_data, 8'hEF);
    chk("t1_stall", stall, 0);
    cyc(); out_issued = 1'b0; tx_ready = 1'b0; #1;
    chk("t1_idle_txv", tx_valid, 0);
    chk("t1_idle_stall", stall, 0);
    chk("t1_tx_bytes", tx_bytes, 1);

    // 2: out word with tx_ready toggling
    tx_exp[0] = 8'h44; tx_exp[1] = 8'h33; tx_exp[2] = 8'h22; tx_exp[3] = 8'h11;
    cyc(); out_issued = 1'b1; size_word = 1'b1; out_data = 32'h11223344; #1;
    chk("t2_acc_stall", stall, 1);
    k = 0;
    for (int c = 0; c < 20 && k < 4; c++) begin
      cyc(); tx_ready = c[0]; #1;
      chk("t2_txv",   tx_valid, 1);
      chk("t2_data",  tx_data, tx_exp[k]);
      chk("t2_stall", stall, !(tx_ready && k == 3));
      if (tx_ready) k++;
    end
    chk("t2_all_bytes", k, 4);
    cyc(); out_issued = 1'b0; tx_ready = 1'b0; #1;
    chk("t2_idle_txv", tx_valid, 0);
    chk("t2_tx_bytes", tx_bytes, 5);

    // 3: in word with gaps on rx_valid
    rx_src[0] = 8'h78; rx_src[1] = 8'h56; rx_src[2] = 8'h34; rx_src[3] = 8'h12;
    cyc(); in_issued = 1'b1; size_word = 1'b1; rx_valid = 1'b0; #1;
    chk("t3_acc_stall", stall, 1);
    chk("t3_acc_rxr",   rx_ready, 0);
    k = 0; pulses = 0;
    for (int c = 0; c < 20 && k < 4; c++) begin
      cyc(); rx_valid = c[0]; rx_data = rx_valid ? rx_src[k] : 8'hFF; #1;
      exp_done = rx_valid && (k == 3);
      chk("t3_rxr",     rx_ready, 1);
      chk("t3_in_done", in_done, exp_done);
      chk("t3_in_data", in_data, exp_done ? 32'h12345678 : 32'h0);
      chk("t3_stall",   stall, !exp_done);
      if (in_done) pulses++;
      if (rx_valid) k++;
    end
    chk("t3_all_bytes", k, 4);
    chk("t3_pulses", pulses, 1);
    cyc(); in_issued = 1'b0; rx_valid = 1'b0; #1;
    chk("t3_idle_done", in_done, 0);
    chk("t3_idle_rxr",  rx_ready, 0);
    chk("t3_rx_bytes",  rx_bytes, 4);

    // 4: in byte
    cyc(); in_issued = 1'b1; size_word = 1'b0; #1;
    chk("t4_acc_stall", stall, 1);
    chk("t4_acc_done",  in_done, 0);
    cyc(); rx_valid = 1'b1; rx_data = 8'hA5; #1;
    chk("t4_done",  in_done, 1);
    chk("t4_data",  in_data, 32'h000000A5);
    chk("t4_stall", stall, 0);
    cyc(); in_issued = 1'b0; rx_valid = 1'b0; #1;
    chk("t4_done_low", in_done, 0);
    chk("t4_data_low", in_data, 0);
    chk("t4_rx_bytes", rx_bytes, 5);

    // 5: both requests high -> out only
    cyc(); out_issued = 1'b1; in_issued = 1'b1; size_word = 1'b0;
    out_data = 32'h0000005A; tx_ready = 1'b1; rx_valid = 1'b1; #1;
    chk("t5_acc_stall", stall, 1);
    cyc(); #1;
    chk("t5_txv",   tx_valid, 1);
    chk("t5_rxr",   rx_ready, 0);
    chk("t5_data",  tx_data, 8'h5A);
    chk("t5_stall", stall, 0);
    cyc(); out_issued = 1'b0; in_issued = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0; #1;
    chk("t5_idle_txv", tx_valid, 0);
    chk("t5_idle_rxr", rx_ready, 0);
    chk("t5_tx_bytes", tx_bytes, 6);
    chk("t5_rx_bytes", rx_bytes, 5);

    // 6: reset after 2 of 4 tx bytes
    cyc(); out_issued = 1'b1; size_word = 1'b1; out_data = 32'hAABBCCDD; tx_ready = 1'b1; #1;
    chk("t6_acc_stall", stall, 1);
    cyc(); #1;
    chk("t6_b0", tx_data, 8'hDD);
    cyc(); #1;
    chk("t6_b1", tx_data, 8'hCC);
    cyc(); rstn = 1'b0; out_issued = 1'b0; #1;
    chk("t6_b2_pending", tx_data, 8'hBB);
    cyc(); rstn = 1'b1; #1;
    chk("t6_rst_txv",   tx_valid, 0);
    chk("t6_rst_stall", stall, 0);
    chk("t6_rst_txb",   tx_bytes, 0);
    chk("t6_rst_rxb",   rx_bytes, 0);
    cyc(); out_issued = 1'b1; size_word = 1'b0; out_data = 32'h00000077; #1;
    chk("t6_new_acc", stall, 1);
    cyc(); #1;
    chk("t6_new_data",  tx_data, 8'h77);
    chk("t6_new_stall", stall, 0);
    cyc(); out_issued = 1'b0; tx_ready = 1'b0; #1;
    chk("t6_new_txb", tx_bytes, 1);
    chk("t6_new_txv", tx_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
